// File: rtl/ring_count_monitor_if.sv
// rtl/ring_count_monitor_if.sv - ring bus observation and monitor status signals
interface ring_count_monitor_if #(
    parameter int WIDTH     = 4,
    parameter int IDXW      = 2,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     ring_in;
    logic                 ring_valid;
    logic                 clear_err;
    logic [IDXW-1:0]      idx;
    logic                 idx_valid;
    logic                 onehot_err;
    logic                 seq_err;
    logic                 wrap;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output ring_in, ring_valid, clear_err,
        input  idx, idx_valid, onehot_err, seq_err, wrap, locked, err_count
    );

    modport slave (
        input  ring_in, ring_valid, clear_err,
        output idx, idx_valid, onehot_err, seq_err, wrap, locked, err_count
    );
endinterface

// File: rtl/ring_count_monitor.sv
// rtl/ring_count_monitor.sv - one-hot rotate-right ring counter checker with lock and error count
module ring_count_monitor #(
    parameter int WIDTH     = 4,
    parameter int IDXW      = 2,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_count_monitor_if.slave  bus
);
    localparam int GW = 4;
    localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [GW-1:0]        good_q, good_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 idx_valid_q, idx_valid_d;
    logic                 onehot_err_q, onehot_err_d;
    logic                 seq_err_q, seq_err_d;
    logic                 wrap_q, wrap_d;
    logic                 locked_q, locked_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic [IDXW:0]        ones;
    logic [IDXW-1:0]      enc;
    logic                 legal;
    logic [WIDTH-1:0]     expected;
    logic                 match;

    always_comb begin
        ones = '0;
        enc  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) begin
                ones = ones + 1'b1;
                enc  = i[IDXW-1:0];
            end
        end
        legal    = (ones == 1);
        expected = {prev_q[0], prev_q[WIDTH-1:1]};
        match    = legal && (bus.ring_in == expected);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        wrap_d       = 1'b0;
        err_d        = err_q;

        if (bus.ring_valid) begin
            if (legal) begin
                idx_d       = enc;
                idx_valid_d = 1'b1;
                prev_d      = bus.ring_in;
            end
            wrap_d = (state_q != SEARCH) && prev_q[0] && match;

            case (state_q)
                SEARCH: begin
                    if (legal) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end else begin
                        onehot_err_d = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!legal) begin
                        onehot_err_d = 1'b1;
                        state_d      = SEARCH;
                    end else if (match) begin
                        good_d = good_q + 1'b1;
                        if (good_q + 1'b1 == LOCK_TARGET) state_d = LOCKED;
                    end else begin
                        seq_err_d = 1'b1;
                        good_d    = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        onehot_err_d = 1'b1;
                        state_d      = SEARCH;
                    end else if (!match) begin
                        seq_err_d = 1'b1;
                        state_d   = ACQUIRE;
                        good_d    = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over a coincident error; the count sticks at all-ones
        if (bus.clear_err) begin
            err_d = '0;
        end else if ((onehot_err_d || seq_err_d) && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            prev_q       <= '0;
            good_q       <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            wrap_q       <= wrap_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign bus.idx        = idx_q;
    assign bus.idx_valid  = idx_valid_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.wrap       = wrap_q;
    assign bus.locked     = locked_q;
    assign bus.err_count  = err_q;
endmodule

// File: doc/ring_count_monitor.md
Name: ring_count_monitor

Overview:
- Receive-side checker for the 4-bit right-rotating one-hot ring counter sequence 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Samples the ring bus, decodes each one-hot code to a binary index and validates legality and sequence order.
- Acquires lock after a run of correct transitions and counts errors.
- Sits at the consuming end of a ring-counter-driven interface, e.g. a phase selector or a health monitor.

Parameters:
- WIDTH, 4, ring width in bits; legal codes have exactly one bit set.
- IDXW, 2, index width; must equal clog2(WIDTH).
- LOCK_CNT, 4, consecutive correct transitions needed to assert locked; range 1..15.
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ring_in  in  WIDTH  ring counter value under observation.
- ring_valid  in  1  ring_in is sampled only on cycles where this is 1.
- clear_err  in  1  synchronous clear of err_count.
- idx  out  IDXW  binary position of the set bit in the last legal sample (1000 gives 3, 0001 gives 0).
- idx_valid  out  1  one-cycle pulse when idx updates.
- onehot_err  out  1  one-cycle pulse: sampled code is not one-hot (zero bits or more than one bit set).
- seq_err  out  1  one-cycle pulse: sampled code is legal but is not the rotate-right of the previous sample.
- wrap  out  1  one-cycle pulse on a correct 0001 -> 1000 transition (bit0 to bit WIDTH-1).
- locked  out  1  level output, high in the LOCKED state.
- err_count  out  ERR_CNT_W  saturating count of error pulses.

Behaviour:
- All outputs are registered. Response appears 1 clk after a sampled cycle (ring_valid=1). Cycles with ring_valid=0 change no state and force all pulses to 0.
- Reset (async, takes effect immediately):
  - idx=0, idx_valid=0, onehot_err=0, seq_err=0, wrap=0, locked=0, err_count=0.
  - state=SEARCH, prev=0, good_cnt=0.
- expected = {prev[0], prev[WIDTH-1:1]}.
- Any legal sample: idx=encode(ring_in), idx_valid=1, prev=ring_in.
- Any illegal sample: idx holds its value; prev is unchanged.
- FSM on each sampled cycle:
  - SEARCH:
    - legal -> ACQUIRE, good_cnt=0.
    - illegal -> onehot_err=1, stay in SEARCH.
  - ACQUIRE:
    - legal and equal to expected -> good_cnt++; when good_cnt reaches LOCK_CNT, go to LOCKED.
    - legal but not expected (including a repeated value) -> seq_err=1, stay in ACQUIRE, good_cnt=0.
    - illegal -> onehot_err=1, go to SEARCH.
  - LOCKED:
    - correct transition -> stay in LOCKED.
    - seq error -> seq_err=1, go to ACQUIRE, good_cnt=0.
    - illegal -> onehot_err=1, go to SEARCH.
    - locked drops in the same cycle the error pulse is asserted.
- wrap=1 when the state is ACQUIRE or LOCKED, prev[0]=1, and ring_in equals expected.
- err_count:
  - Increments by 1 on every onehot_err or seq_err pulse, in any state.
  - Saturates at all-ones; never wraps.
  - clear_err has priority: clear and error in the same cycle gives 0.
- onehot_err and seq_err are mutually exclusive.
- Reset asserted mid-lock clears everything; after release the monitor must re-acquire from SEARCH.

Test Plan:
1. Reset, then feed 1000,0100,0010,0001,1000 with ring_valid=1 -> idx 3,2,1,0,3 with idx_valid each cycle; locked rises 1 clk after the 5th sample (4 good transitions); wrap pulses once, on the 5th sample; no errors.
2. Locked, then ring_valid toggles 1,0,0,1 around 0100 -> 0010 -> lock is held across the gaps; no pulses on the gap cycles.
3. Locked at 0100, feed 0110 -> onehot_err=1, locked=0, err_count=1, idx stays 2. Then feed 0000 -> onehot_err=1, err_count=2. Then feed 0010 -> state ACQUIRE, idx=1.
4. Locked at 1000, feed 0010 (skip) -> seq_err=1, err_count+1, locked=0. Then four correct transitions -> locked=1 again.
5. Force 300 illegal samples with ERR_CNT_W=8 -> err_count saturates at 255. Then clear_err together with another error -> err_count=0.
6. Assert rst asynchronously between clock edges while locked with err_count=5 -> all outputs are 0 immediately. After release, 0010 is acquired and lock requires LOCK_CNT new transitions.
